// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the two-requester I2C register-engine arbiter.
package i2c_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int DEV_W   = 7;
    localparam int REG_W   = 8;
    localparam int DAT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] owner_mask(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Down-counter reloaded by clear; expire is high once LIMIT cycles have elapsed since the last clear.
module arb_watchdog #(
    parameter int unsigned LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CNT_W-1:0] cnt;

    // The reload value is LIMIT-1 so expire rises in the LIMIT-th cycle of a state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter with bus lock sharing one I2C register engine between the sensor and OLED paths.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned P_SYS_CLK    = 50_000_000,
    parameter int unsigned P_TIMEOUT_US = 20_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       grant,
    input  logic [NUM_REQ-1:0]       cmd_valid,
    output logic [NUM_REQ-1:0]       cmd_ready,
    input  logic [NUM_REQ*DEV_W-1:0] cmd_dev,
    input  logic [NUM_REQ*REG_W-1:0] cmd_reg,
    input  logic [NUM_REQ*DAT_W-1:0] cmd_wdata,
    input  logic [NUM_REQ-1:0]       cmd_rnw,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DAT_W-1:0]         rsp_rdata,
    output logic                     rsp_err,
    output logic                     eng_start,
    output logic [DEV_W-1:0]         eng_dev,
    output logic [REG_W-1:0]         eng_reg,
    output logic [DAT_W-1:0]         eng_wdata,
    output logic                     eng_rnw,
    input  logic                     eng_done,
    input  logic [DAT_W-1:0]         eng_rdata,
    input  logic                     eng_nack,
    output logic                     eng_abort,
    output logic                     timeout_evt,
    output logic [7:0]               nack_cnt,
    output arb_state_t               dbg_state
);

    localparam int unsigned LIMIT = (P_SYS_CLK / 1_000_000) * P_TIMEOUT_US;

    arb_state_t state, state_nx;
    logic owner, owner_nx;
    logic last, last_nx;
    logic accept, abort_nx, tmo_nx;
    logic wd_expire;

    logic [DEV_W-1:0] dev_sel;
    logic [REG_W-1:0] reg_sel;
    logic [DAT_W-1:0] wdata_sel;

    arb_watchdog #(.LIMIT(LIMIT)) u_watchdog (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .clear  (state_nx != state),
        .expire (wd_expire)
    );

    // Command handshake: a command transfers on a cycle where cmd_valid[i] and cmd_ready[i]
    // are both high; cmd_ready is only ever raised for the current owner while in OWN.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        accept   = 1'b0;
        abort_nx = 1'b0;
        tmo_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != '0) begin
                    owner_nx = (req == 2'b11) ? ~last : req[1];
                    last_nx  = owner_nx;
                    state_nx = ST_OWN;
                end
            end
            ST_OWN: begin
                if (cmd_valid[owner]) begin
                    accept   = 1'b1;
                    state_nx = ST_WAIT;
                end else if (!req[owner]) begin
                    state_nx = ST_IDLE;
                end else if (wd_expire) begin
                    tmo_nx   = 1'b1;
                    last_nx  = owner;
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A completion arriving with the expiry wins; no abort is sent then.
                if (eng_done) begin
                    state_nx = ST_RESP;
                end else if (wd_expire) begin
                    abort_nx = 1'b1;
                    tmo_nx   = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nx = req[owner] ? ST_OWN : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        dev_sel   = cmd_dev[DEV_W*int'(owner) +: DEV_W];
        reg_sel   = cmd_reg[REG_W*int'(owner) +: REG_W];
        wdata_sel = cmd_wdata[DAT_W*int'(owner) +: DAT_W];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            eng_start   <= 1'b0;
            eng_abort   <= 1'b0;
            timeout_evt <= 1'b0;
            eng_dev     <= '0;
            eng_reg     <= '0;
            eng_wdata   <= '0;
            eng_rnw     <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            nack_cnt    <= 8'd0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            last        <= last_nx;
            eng_start   <= accept;
            eng_abort   <= abort_nx;
            timeout_evt <= tmo_nx;
            if (accept) begin
                eng_dev   <= dev_sel;
                eng_reg   <= reg_sel;
                eng_wdata <= wdata_sel;
                eng_rnw   <= cmd_rnw[owner];
            end
            if (state == ST_WAIT && eng_done) begin
                rsp_rdata <= eng_rdata;
                rsp_err   <= eng_nack;
            end else if (abort_nx) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
            if (state == ST_RESP && rsp_err && nack_cnt != 8'hFF) begin
                nack_cnt <= nack_cnt + 8'd1;
            end
        end
    end

    assign grant     = (state != ST_IDLE) ? owner_mask(owner) : '0;
    assign cmd_ready = (state == ST_OWN)  ? owner_mask(owner) : '0;
    assign rsp_valid = (state == ST_RESP) ? owner_mask(owner) : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed plus randomized bench for i2c_bus_arbiter against a transaction-level model of grants and responses.
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    localparam int LIMIT = 8;  // 1 MHz clock and an 8 us timeout give an 8-cycle watchdog

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_ready;
    logic [13:0] cmd_dev;
    logic [15:0] cmd_reg;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_rnw;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        eng_start;
    logic [6:0]  eng_dev;
    logic [7:0]  eng_reg;
    logic [7:0]  eng_wdata;
    logic        eng_rnw;
    logic        eng_done;
    logic [7:0]  eng_rdata;
    logic        eng_nack;
    logic        eng_abort;
    logic        timeout_evt;
    logic [7:0]  nack_cnt;
    arb_state_t  dbg_state;

    int n_vec;
    int n_fail;
    int m_last;
    int m_nack;
    logic [8:0] exp_q[$];

    i2c_bus_arbiter #(.P_SYS_CLK(1_000_000), .P_TIMEOUT_US(8)) dut (
        .sys_clk(clk), .sys_rst(rst), .req(req), .grant(grant),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
        .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_rnw(cmd_rnw),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_dev(eng_dev), .eng_reg(eng_reg),
        .eng_wdata(eng_wdata), .eng_rnw(eng_rnw), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .eng_nack(eng_nack), .eng_abort(eng_abort),
        .timeout_evt(timeout_evt), .nack_cnt(nack_cnt), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [1:0] r);
        if (r == 2'b11) return 1 - m_last;
        return r[1] ? 1 : 0;
    endfunction

    task automatic junk();
        cmd_dev   = 14'($urandom);
        cmd_reg   = 16'($urandom);
        cmd_wdata = 16'($urandom);
        cmd_rnw   = 2'($urandom);
    endtask

    // DUT is IDLE with req already driven: the next edge grants the model's winner.
    task automatic arbitrate(output int o);
        o = model_pick(req);
        m_last = o;
        tick();
        chk("grant", 32'(grant), 32'(1 << o));
        chk("cmd_ready", 32'(cmd_ready), 32'(1 << o));
    endtask

    task automatic do_cmd(input int o, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic rnw, input logic [7:0] rd,
                          input logic nk, input int dly, input logic [1:0] ra, input logic early);
        logic [23:0] exp_f;
        logic [8:0]  exp_r;
        exp_f = {dev, rg, wd, rnw};
        junk();
        cmd_dev[7*o +: 7]   = dev;
        cmd_reg[8*o +: 8]   = rg;
        cmd_wdata[8*o +: 8] = wd;
        cmd_rnw[o]          = rnw;
        cmd_valid = 2'(1 << o) | 2'($urandom_range(0, 1) << (1 - o));
        chk("cmd_ready_own", 32'(cmd_ready), 32'(1 << o));
        tick();
        cmd_valid = 2'($urandom_range(0, 1) << (1 - o));
        junk();
        if (early) req = ra;
        chk("eng_start", 32'(eng_start), 32'd1);
        chk("eng_fields", 32'({eng_dev, eng_reg, eng_wdata, eng_rnw}), 32'(exp_f));
        chk("grant_wait", 32'(grant), 32'(1 << o));
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("eng_start_pulse", 32'(eng_start), 32'd0);
            chk("eng_hold", 32'({eng_dev, eng_reg, eng_wdata, eng_rnw}), 32'(exp_f));
            chk("rsp_early", 32'(rsp_valid), 32'd0);
            junk();
        end
        eng_done  = 1'b1;
        eng_rdata = rd;
        eng_nack  = nk;
        exp_q.push_back({nk, rd});
        tick();
        eng_done  = 1'b0;
        eng_rdata = 8'($urandom);
        eng_nack  = 1'($urandom_range(0, 1));
        cmd_valid = 2'b00;
        exp_r = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << o));
        chk("rsp_data", 32'({rsp_err, rsp_rdata}), 32'(exp_r));
        chk("no_abort", 32'({eng_abort, timeout_evt}), 32'd0);
        if (nk && m_nack < 255) m_nack++;
        req = ra;
        tick();
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("grant_after", 32'(grant), ra[o] ? 32'(1 << o) : 32'd0);
        chk("nack_cnt", 32'(nack_cnt), 32'(m_nack));
    endtask

    task automatic do_hang(input int o, input logic [1:0] ra);
        logic [23:0] exp_f;
        junk();
        exp_f = {cmd_dev[7*o +: 7], cmd_reg[8*o +: 8], cmd_wdata[8*o +: 8], cmd_rnw[o]};
        cmd_valid = 2'(1 << o);
        tick();
        cmd_valid = 2'b00;
        chk("hang_start", 32'(eng_start), 32'd1);
        chk("hang_fields", 32'({eng_dev, eng_reg, eng_wdata, eng_rnw}), 32'(exp_f));
        for (int i = 1; i < LIMIT; i++) begin
            tick();
            chk("hang_quiet", 32'({eng_abort, timeout_evt, rsp_valid}), 32'd0);
        end
        tick();
        chk("hang_abort", 32'({eng_abort, timeout_evt}), 32'b11);
        chk("hang_rsp", 32'(rsp_valid), 32'(1 << o));
        chk("hang_err", 32'(rsp_err), 32'd1);
        if (m_nack < 255) m_nack++;
        req = ra;
        tick();
        chk("abort_pulse", 32'({eng_abort, timeout_evt}), 32'd0);
        chk("hang_nack_cnt", 32'(nack_cnt), 32'(m_nack));
    endtask

    initial begin
        int o;
        int n;
        logic [1:0] r;
        logic [1:0] ra;
        n_vec = 0;
        n_fail = 0;
        m_last = 1;
        m_nack = 0;
        rst = 1'b1;
        req = 2'b00;
        cmd_valid = 2'b00;
        cmd_dev = '0;
        cmd_reg = '0;
        cmd_wdata = '0;
        cmd_rnw = '0;
        eng_done = 1'b0;
        eng_rdata = '0;
        eng_nack = 1'b0;
        repeat (3) tick();
        chk("rst_outs", 32'({grant, cmd_ready, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_abort, timeout_evt}), 32'd0);
        chk("rst_eng", 32'({eng_dev, eng_reg, eng_wdata, eng_rnw}), 32'd0);
        chk("rst_nack", 32'(nack_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        chk("idle_grant", 32'(grant), 32'd0);

        // Simultaneous requests: requester 0 wins the first tie, then hands over on drop.
        req = 2'b11;
        arbitrate(o);
        chk("first_tie", 32'(o), 32'd0);
        do_cmd(o, 7'h3C, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 1, 2'b11, 1'b0);
        req = 2'b10;
        tick();
        chk("drop_grant", 32'(grant), 32'd0);
        arbitrate(o);

        do_cmd(o, 7'h57, 8'hFF, 8'h42, 1'b1, 8'h15, 1'b0, 3, 2'b00, 1'b0);

        // Locked burst by requester 0 while requester 1 keeps requesting.
        req = 2'b11;
        arbitrate(o);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("stray_done", 32'(rsp_valid), 32'd0);
        chk("stray_done_own", 32'(cmd_ready), 32'(1 << o));
        for (int k = 0; k < 3; k++) begin
            do_cmd(o, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   8'($urandom), 1'b0, $urandom_range(0, 3), (k < 2) ? 2'b11 : 2'b10, 1'b0);
        end
        arbitrate(o);

        do_cmd(o, 7'h11, 8'h22, 8'h33, 1'b1, 8'h44, 1'b1, 2, 2'b10, 1'b0);
        do_cmd(o, 7'h12, 8'h23, 8'h34, 1'b0, 8'h45, 1'b1, 0, 2'b10, 1'b0);
        chk("nack_two", 32'(nack_cnt), 32'd2);
        do_cmd(o, 7'h13, 8'h24, 8'h35, 1'b1, 8'h46, 1'b0, LIMIT - 1, 2'b00, 1'b1);

        // Engine never completes.
        req = 2'b01;
        arbitrate(o);
        do_hang(o, 2'b00);

        for (int it = 0; it < 30; it++) begin
            r = 2'($urandom_range(1, 3));
            req = r;
            arbitrate(o);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                if (k < n - 1) ra = 2'(1 << o) | 2'($urandom_range(0, 1) << (1 - o));
                else ra = 2'b00;
                do_cmd(o, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                       8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, LIMIT - 1),
                       ra, 1'($urandom_range(0, 1)));
            end
        end

        // Owner that never issues a command loses the grant.
        req = 2'b11;
        arbitrate(o);
        for (int i = 1; i < LIMIT; i++) begin
            tick();
            chk("idle_hold", 32'(grant), 32'(1 << o));
        end
        tick();
        chk("idle_revoke", 32'(grant), 32'd0);
        chk("idle_tmo", 32'(timeout_evt), 32'd1);
        m_last = o;
        arbitrate(o);
        chk("idle_tmo_pulse", 32'(timeout_evt), 32'd0);

        for (int k = 0; k < 300; k++) begin
            do_cmd(o, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   8'($urandom), 1'b1, 0, 2'b11, 1'b0);
        end
        chk("nack_sat", 32'(nack_cnt), 32'd255);

        // Reset while a transaction is in flight.
        cmd_valid = 2'(1 << o);
        tick();
        cmd_valid = 2'b00;
        chk("pre_rst_start", 32'(eng_start), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({grant, cmd_ready, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_abort, timeout_evt}), 32'd0);
        chk("mid_rst_eng", 32'({eng_dev, eng_reg, eng_wdata, eng_rnw}), 32'd0);
        chk("mid_rst_nack", 32'(nack_cnt), 32'd0);
        req = 2'b00;
        repeat (2) tick();
        rst = 1'b0;
        m_last = 1;
        m_nack = 0;
        req = 2'b11;
        arbitrate(o);
        chk("post_rst_tie", 32'(o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
